// File: rtl/mem_layout_pkg.sv
// Shared memory-map layout definitions for the PS->RTL wide-register assemblers:
// AXI-lite response codes and the per-instance word counts of the wide registers.
package mem_layout_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    // Width of one memory-map data entry
    localparam int WD_DATA_WIDTH = 16;

    // Sample counts carried by each wide register and their sample widths
    localparam int BATCH_SAMPLES  = 32;
    localparam int BATCH_SAMPLE_W = 8;
    localparam int CHAN_SAMPLES   = 8;
    localparam int CHAN_SAMPLE_W  = 16;
    localparam int SDC_SAMPLES    = 12;
    localparam int SDC_SAMPLE_W   = 12;

    // Number of mem-map words needed to hold a packed array of samples (rounded up)
    function automatic int words_for(input int samples, input int sample_w, input int word_w);
        return (samples * sample_w + word_w - 1) / word_w;
    endfunction

    localparam int BATCH_NUM_WORDS = words_for(BATCH_SAMPLES, BATCH_SAMPLE_W, WD_DATA_WIDTH);
    localparam int CHAN_NUM_WORDS  = words_for(CHAN_SAMPLES, CHAN_SAMPLE_W, WD_DATA_WIDTH);
    localparam int SDC_NUM_WORDS   = words_for(SDC_SAMPLES, SDC_SAMPLE_W, WD_DATA_WIDTH);

endpackage

// File: rtl/bigreg_fifo.sv
// Synchronous FIFO holding committed wide-register values.
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
// When empty, dout keeps presenting the last value that was popped.
module bigreg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_hold;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop  = pop & ~empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign w_push = push & (~full | w_pop);
    assign dout   = empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];

    // Storage array: written at the write pointer on every accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers and the last-popped value shown while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ps_bigreg_assembler.sv
// PS->RTL wide-register assembler. Word writes fill a shadow register and mark
// fresh bits; a write to index NUM_WORDS commits the shadow into a queue that
// RTL consumers drain with valid/ready. Dropped commits raise a sticky overflow.
// Optional feature macro: PS_BIGREG_PARTIAL_COMMIT_EN (commits from a partly
// written shadow merge fresh words with the last committed value).
module ps_bigreg_assembler
    import mem_layout_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_WORDS  = 16,
    parameter int REQ_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [$clog2(NUM_WORDS+1)-1:0]    wr_idx,
    input  logic [WORD_WIDTH-1:0]             wr_data,
    output logic                              resp_valid,
    output logic [1:0]                        resp,
    output logic [NUM_WORDS-1:0]              fresh_mask,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]   out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              overflow,
    input  logic                              clr_overflow
);

    localparam int                IDX_W     = $clog2(NUM_WORDS + 1);
    localparam int                REG_W     = NUM_WORDS * WORD_WIDTH;
    localparam logic [IDX_W-1:0]  VALID_IDX = IDX_W'(NUM_WORDS);

    // Collection state, derived from the fresh bits rather than stored
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULLSET = 2'd2;

`ifdef PS_BIGREG_PARTIAL_COMMIT_EN
    localparam bit PARTIAL_OK = 1'b1;
`else
    localparam bit PARTIAL_OK = 1'b0;
`endif

    logic [REG_W-1:0]     r_shadow;
    logic [NUM_WORDS-1:0] r_fresh;
    logic                 r_overflow;
    logic                 r_resp_valid;
    axi_resp_t            r_resp;

    logic [1:0]           w_state;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_clr_fresh;
    logic                 w_word_wr;
    axi_resp_t            w_resp;
    logic [REG_W-1:0]     w_push_data;

    assign fresh_mask = r_fresh;
    assign overflow   = r_overflow;
    assign resp_valid = r_resp_valid;
    assign resp       = r_resp;
    assign out_valid  = ~w_empty;
    assign w_pop      = ~w_empty & out_ready;

    // Classify the shadow as idle, partly collected or completely collected
    always_comb begin
        w_state = ST_COLLECT;
        if (r_fresh == '0) begin
            w_state = ST_IDLE;
        end else if (&r_fresh) begin
            w_state = ST_FULLSET;
        end
    end

    // Decode the mem-map write into shadow update, push, drop and response
    always_comb begin
        w_resp      = OKAY;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_clr_fresh = 1'b0;
        w_word_wr   = 1'b0;
        if (wr_en) begin
            if (wr_idx < VALID_IDX) begin
                w_word_wr = 1'b1;
            end else if (wr_idx == VALID_IDX) begin
                w_clr_fresh = 1'b1;
                if ((w_state == ST_FULLSET) || PARTIAL_OK) begin
                    // A full queue still accepts when the head pops this cycle
                    if (!w_full || w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                        w_resp = SLVERR;
                    end
                end else begin
                    w_resp = SLVERR;
                end
            end else begin
                w_resp = SLVERR;
            end
        end
    end

`ifdef PS_BIGREG_PARTIAL_COMMIT_EN
    logic [REG_W-1:0] r_last;

    // Merge fresh shadow words over the last committed value
    always_comb begin
        w_push_data = r_last;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (r_fresh[i]) begin
                w_push_data[i*WORD_WIDTH +: WORD_WIDTH] = r_shadow[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Remember the most recent value actually pushed into the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
        end else if (w_push) begin
            r_last <= w_push_data;
        end
    end
`else
    assign w_push_data = r_shadow;
`endif

    // Shadow words and their fresh bits; any commit attempt clears the fresh bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_fresh  <= '0;
        end else if (w_clr_fresh) begin
            r_fresh <= '0;
        end else if (w_word_wr) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    r_shadow[i*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
                    r_fresh[i]                           <= 1'b1;
                end
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Registered write response, one cycle after the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp       <= OKAY;
        end else begin
            r_resp_valid <= wr_en;
            r_resp       <= w_resp;
        end
    end

    bigreg_fifo #(
        .WIDTH (REG_W),
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_data),
        .full  (w_full),
        .empty (w_empty),
        .dout  (out_data)
    );

endmodule

// File: tb/tb_ps_bigreg_assembler.sv
// Self-checking bench for ps_bigreg_assembler (WORD_WIDTH=16, NUM_WORDS=4, REQ_DEPTH=2).
// Table-driven directed vectors, hand-written corner sequences and a randomized
// run checked against a queue-based reference model.
module tb_ps_bigreg_assembler;

    localparam int WW = 16;
    localparam int NW = 4;
    localparam int RD = 2;
    localparam int IW = 3;
    localparam int RW = NW * WW;
    localparam logic [1:0] R_OK  = 2'b00;
    localparam logic [1:0] R_ERR = 2'b10;

`ifdef PS_BIGREG_PARTIAL_COMMIT_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [WW-1:0] wr_data = '0;
    logic          out_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          resp_valid;
    logic [1:0]    resp;
    logic [NW-1:0] fresh_mask;
    logic [RW-1:0] out_data;
    logic          out_valid;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps_bigreg_assembler #(
        .WORD_WIDTH (WW),
        .NUM_WORDS  (NW),
        .REQ_DEPTH  (RD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .resp_valid   (resp_valid),
        .resp         (resp),
        .fresh_mask   (fresh_mask),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Reference model state
    logic [WW-1:0] m_sh [NW];
    logic [NW-1:0] m_fr;
    logic [RW-1:0] m_q [$];
    logic [RW-1:0] m_last;
    logic [RW-1:0] m_hold;
    logic          m_ovf;
    logic          m_rv;
    logic [1:0]    m_resp;

    typedef struct {
        logic          we;
        logic [IW-1:0] idx;
        logic [WW-1:0] d;
        logic          rdy;
        logic          clr;
        logic [1:0]    resp;
        logic [NW-1:0] fresh;
        logic          ov;
        logic [RW-1:0] od;
        logic          ovf;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_sh[i] = '0;
        m_fr   = '0;
        m_q.delete();
        m_last = '0;
        m_hold = '0;
        m_ovf  = 1'b0;
        m_rv   = 1'b0;
        m_resp = R_OK;
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model, wait to the next negedge
    task automatic step(input logic we, input logic [IW-1:0] idx, input logic [WW-1:0] d,
                        input logic rdy, input logic clr);
        bit            pop;
        bit            was_full;
        bit            set_ovf;
        logic [RW-1:0] val;
        wr_en        = we;
        wr_idx       = idx;
        wr_data      = d;
        out_ready    = rdy;
        clr_overflow = clr;
        was_full = (m_q.size() == RD);
        pop      = (m_q.size() != 0) && rdy;
        set_ovf  = 1'b0;
        m_rv     = we;
        m_resp   = R_OK;
        if (pop) m_hold = m_q.pop_front();
        if (we) begin
            if (idx < NW) begin
                m_sh[idx] = d;
                m_fr[idx] = 1'b1;
            end else if (idx == NW) begin
                if (m_fr == {NW{1'b1}} || PARTIAL) begin
                    for (int w = 0; w < NW; w++)
                        val[w*WW +: WW] = m_fr[w] ? m_sh[w] : m_last[w*WW +: WW];
                    if (!was_full || pop) begin
                        m_q.push_back(val);
                        m_last = val;
                    end else begin
                        set_ovf = 1'b1;
                        m_resp  = R_ERR;
                    end
                end else begin
                    m_resp = R_ERR;
                end
                m_fr = '0;
            end else begin
                m_resp = R_ERR;
            end
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_resp_valid"}, RW'(resp_valid), RW'(m_rv));
        if (m_rv) chk({tag, "_resp"}, RW'(resp), RW'(m_resp));
        chk({tag, "_fresh"}, RW'(fresh_mask), RW'(m_fr));
        chk({tag, "_out_valid"}, RW'(out_valid), RW'(m_q.size() != 0));
        chk({tag, "_out_data"}, out_data, (m_q.size() != 0) ? m_q[0] : m_hold);
        chk({tag, "_overflow"}, RW'(overflow), RW'(m_ovf));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_resp_valid"}, RW'(resp_valid), '0);
        chk({tag, "_resp"}, RW'(resp), RW'(R_OK));
        chk({tag, "_fresh"}, RW'(fresh_mask), '0);
        chk({tag, "_out_valid"}, RW'(out_valid), '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_overflow"}, RW'(overflow), '0);
    endtask

    // Four word writes of base+1..base+4 followed by a commit, all with out_ready low
    task automatic full_commit(input logic [WW-1:0] base, input string tag);
        for (int w = 0; w < NW; w++) begin
            step(1'b1, IW'(w), base + WW'(w + 1), 1'b0, 1'b0);
            check_model(tag);
        end
        step(1'b1, IW'(NW), '0, 1'b0, 1'b0);
        check_model(tag);
    endtask

    localparam logic [RW-1:0] C1 = 64'h0004_0003_0002_0001;
    localparam logic [RW-1:0] C2 = 64'h0008_0007_0006_0005;

    initial begin
        tbl[0]  = '{1'b1, 3'd0, 16'd1,  1'b0, 1'b0, R_OK,  4'b0001, 1'b0, 64'h0, 1'b0};
        tbl[1]  = '{1'b1, 3'd1, 16'd2,  1'b0, 1'b0, R_OK,  4'b0011, 1'b0, 64'h0, 1'b0};
        tbl[2]  = '{1'b1, 3'd2, 16'd3,  1'b0, 1'b0, R_OK,  4'b0111, 1'b0, 64'h0, 1'b0};
        tbl[3]  = '{1'b1, 3'd3, 16'd4,  1'b0, 1'b0, R_OK,  4'b1111, 1'b0, 64'h0, 1'b0};
        tbl[4]  = '{1'b1, 3'd4, 16'd0,  1'b0, 1'b0, R_OK,  4'b0000, 1'b1, C1,    1'b0};
        tbl[5]  = '{1'b1, 3'd0, 16'd5,  1'b0, 1'b0, R_OK,  4'b0001, 1'b1, C1,    1'b0};
        tbl[6]  = '{1'b1, 3'd1, 16'd6,  1'b0, 1'b0, R_OK,  4'b0011, 1'b1, C1,    1'b0};
        tbl[7]  = '{1'b1, 3'd2, 16'd7,  1'b0, 1'b0, R_OK,  4'b0111, 1'b1, C1,    1'b0};
        tbl[8]  = '{1'b1, 3'd3, 16'd8,  1'b0, 1'b0, R_OK,  4'b1111, 1'b1, C1,    1'b0};
        tbl[9]  = '{1'b1, 3'd4, 16'd0,  1'b0, 1'b0, R_OK,  4'b0000, 1'b1, C1,    1'b0};
        tbl[10] = '{1'b1, 3'd0, 16'd9,  1'b0, 1'b0, R_OK,  4'b0001, 1'b1, C1,    1'b0};
        tbl[11] = '{1'b1, 3'd1, 16'd10, 1'b0, 1'b0, R_OK,  4'b0011, 1'b1, C1,    1'b0};
        tbl[12] = '{1'b1, 3'd2, 16'd11, 1'b0, 1'b0, R_OK,  4'b0111, 1'b1, C1,    1'b0};
        tbl[13] = '{1'b1, 3'd3, 16'd12, 1'b0, 1'b0, R_OK,  4'b1111, 1'b1, C1,    1'b0};
        tbl[14] = '{1'b1, 3'd4, 16'd0,  1'b0, 1'b0, R_ERR, 4'b0000, 1'b1, C1,    1'b1};
        tbl[15] = '{1'b0, 3'd0, 16'd0,  1'b1, 1'b0, R_OK,  4'b0000, 1'b1, C2,    1'b1};
        tbl[16] = '{1'b0, 3'd0, 16'd0,  1'b1, 1'b0, R_OK,  4'b0000, 1'b0, C2,    1'b1};
        tbl[17] = '{1'b0, 3'd0, 16'd0,  1'b0, 1'b1, R_OK,  4'b0000, 1'b0, C2,    1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Directed table: full commit, back-pressure overflow and ordered drain
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].we, tbl[i].idx, tbl[i].d, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_resp_valid", i), RW'(resp_valid), RW'(tbl[i].we));
            if (tbl[i].we) chk($sformatf("tbl%0d_resp", i), RW'(resp), RW'(tbl[i].resp));
            chk($sformatf("tbl%0d_fresh", i), RW'(fresh_mask), RW'(tbl[i].fresh));
            chk($sformatf("tbl%0d_out_valid", i), RW'(out_valid), RW'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
            chk($sformatf("tbl%0d_overflow", i), RW'(overflow), RW'(tbl[i].ovf));
        end

        // Same-cycle pop lets a commit into a full queue
        full_commit(16'h10, "fill_a");
        full_commit(16'h20, "fill_b");
        for (int w = 0; w < NW; w++) begin
            step(1'b1, IW'(w), 16'h30 + WW'(w + 1), 1'b0, 1'b0);
            check_model("samepop_wr");
        end
        step(1'b1, IW'(NW), '0, 1'b1, 1'b0);
        chk("samepop_resp", RW'(resp), RW'(R_OK));
        chk("samepop_overflow", RW'(overflow), '0);
        check_model("samepop");
        repeat (2) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            check_model("samepop_drain");
        end
        chk("samepop_last", out_data, 64'h0034_0033_0032_0031);

        // Commit from a partly written shadow
        step(1'b1, 3'd0, 16'hAAAA, 1'b0, 1'b0);
        check_model("partial_wr");
        step(1'b1, 3'd4, '0, 1'b0, 1'b0);
        if (PARTIAL) begin
            chk("partial_resp", RW'(resp), RW'(R_OK));
            chk("partial_out_valid", RW'(out_valid), 64'd1);
            chk("partial_out_data", out_data, 64'h0034_0033_0032_AAAA);
        end else begin
            chk("partial_resp", RW'(resp), RW'(R_ERR));
            chk("partial_out_valid", RW'(out_valid), 64'd0);
        end
        chk("partial_fresh", RW'(fresh_mask), '0);
        check_model("partial");
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check_model("partial_drain");

        // Out-of-range indices leave everything alone
        step(1'b1, 3'd1, 16'h5555, 1'b0, 1'b0);
        check_model("oor_wr");
        step(1'b1, 3'd5, 16'h1234, 1'b0, 1'b0);
        chk("oor5_resp", RW'(resp), RW'(R_ERR));
        chk("oor5_fresh", RW'(fresh_mask), 64'b0010);
        check_model("oor5");
        step(1'b1, 3'd7, 16'h4321, 1'b0, 1'b0);
        chk("oor7_resp", RW'(resp), RW'(R_ERR));
        check_model("oor7");

        // Asynchronous reset mid-collection with an entry pending
        full_commit(16'h40, "rst_fill");
        step(1'b1, 3'd0, 16'hBEEF, 1'b0, 1'b0);
        step(1'b1, 3'd1, 16'hCAFE, 1'b0, 1'b0);
        chk("prerst_fresh", RW'(fresh_mask), 64'b0011);
        chk("prerst_out_valid", RW'(out_valid), 64'd1);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_model("post_rst");

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic          we;
            logic [IW-1:0] idx;
            int            r;
            we = ($urandom_range(0, 99) < 65);
            r  = $urandom_range(0, 15);
            if (r < 10) idx = IW'(r % NW);
            else if (r < 14) idx = IW'(NW);
            else idx = IW'(5 + (r % 3));
            step(we, idx, WW'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
            check_model("rand");
        end

        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
